// File: rtl/onbellek_ffram.sv
// Flip-flop data/tag RAM for the cache controllers: byte-lane writes,
// built-in clear sequencer and write-first forwarding on registered reads.
module onbellek_ffram #(
  parameter int BYTES_N    = 5,
  parameter int EXTRA_BITS = 1,
  parameter int DEPTH      = 512,
  parameter int REG_READ   = 1,
  localparam int DATA_W    = 8 * BYTES_N + EXTRA_BITS,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              temizle_i,
  output logic              hazir_o,
  input  logic [BYTES_N-1:0] wen_i,
  input  logic [ADDR_W-1:0] wadr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ren_i,
  input  logic [ADDR_W-1:0] radr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              gecerli_o
);

  typedef enum logic {
    TEMIZLE,
    HAZIR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] sayac_q;
  logic [ADDR_W-1:0] sayac_d;
  logic              clr_we;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_raw;
  logic              w_ok;
  logic              r_ok;
  logic              usr_we;
  logic              fwd_hit;

  // Side bits above the top lane share that lane's enable.
  for (genvar b = 0; b < DATA_W; b++) begin : g_mask
    localparam int L = (b / 8 >= BYTES_N) ? BYTES_N - 1 : b / 8;
    assign mask[b] = wen_i[L];
  end

  if (DEPTH == (1 << ADDR_W)) begin : g_full
    assign w_ok = 1'b1;
    assign r_ok = 1'b1;
  end else begin : g_part
    assign w_ok = (wadr_i <= LAST);
    assign r_ok = (radr_i <= LAST);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TEMIZLE;
      sayac_q <= '0;
    end else begin
      state_q <= state_d;
      sayac_q <= sayac_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sayac_d = sayac_q;
    clr_we  = 1'b0;
    unique case (state_q)
      TEMIZLE: begin
        clr_we = ~rst_i;
        if (sayac_q == LAST) begin
          state_d = HAZIR;
          sayac_d = '0;
        end else begin
          sayac_d = sayac_q + 1'b1;
        end
      end
      HAZIR: begin
        if (temizle_i) begin
          state_d = TEMIZLE;
          sayac_d = '0;
        end
      end
      default: begin
        state_d = TEMIZLE;
        sayac_d = '0;
      end
    endcase
  end

  assign hazir_o = (state_q == HAZIR);
  assign usr_we  = hazir_o & ~rst_i & w_ok & (|wen_i);
  assign rd_raw  = r_ok ? mem[radr_i] : '0;
  assign wr_word = (mem[wadr_i] & ~mask)
                 | (data_i & mask);

  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[sayac_q] <= '0;
    end else if (usr_we) begin
      mem[wadr_i] <= wr_word;
    end
  end

  assign fwd_hit = usr_we & (radr_i == wadr_i);

  if (REG_READ != 0) begin : g_reg
    logic [DATA_W-1:0] rd_word;

    assign rd_word = fwd_hit
                   ? ((rd_raw & ~mask) | (data_i & mask))
                   : rd_raw;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        data_o    <= '0;
        gecerli_o <= 1'b0;
      end else if (!hazir_o) begin
        if (ren_i) begin
          data_o <= '0;
        end
        gecerli_o <= 1'b0;
      end else begin
        if (ren_i) begin
          data_o <= rd_word;
        end
        gecerli_o <= ren_i;
      end
    end
  end else begin : g_comb
    logic unused_ren;

    assign unused_ren = ren_i ^ fwd_hit;
    assign data_o     = rd_raw;
    assign gecerli_o  = hazir_o;
  end

endmodule

// File: tb/tb_onbellek_ffram.sv
// Directed bench for onbellek_ffram: registered 512x41 instance and
// combinational-read 6x32 instance driven from one clock and reset.
module tb_onbellek_ffram;

  logic clk;
  logic rst;

  logic        temizle_a;
  logic        hazir_a;
  logic [4:0]  wen_a;
  logic [8:0]  wadr_a;
  logic [40:0] din_a;
  logic        ren_a;
  logic [8:0]  radr_a;
  logic [40:0] dout_a;
  logic        gecerli_a;

  logic        temizle_b;
  logic        hazir_b;
  logic [3:0]  wen_b;
  logic [2:0]  wadr_b;
  logic [31:0] din_b;
  logic        ren_b;
  logic [2:0]  radr_b;
  logic [31:0] dout_b;
  logic        gecerli_b;

  int tests;
  int fails;

  onbellek_ffram u_a (
    .clk_i     (clk),
    .rst_i     (rst),
    .temizle_i (temizle_a),
    .hazir_o   (hazir_a),
    .wen_i     (wen_a),
    .wadr_i    (wadr_a),
    .data_i    (din_a),
    .ren_i     (ren_a),
    .radr_i    (radr_a),
    .data_o    (dout_a),
    .gecerli_o (gecerli_a)
  );

  onbellek_ffram #(
    .BYTES_N    (4),
    .EXTRA_BITS (0),
    .DEPTH      (6),
    .REG_READ   (0)
  ) u_b (
    .clk_i     (clk),
    .rst_i     (rst),
    .temizle_i (temizle_b),
    .hazir_o   (hazir_b),
    .wen_i     (wen_b),
    .wadr_i    (wadr_b),
    .data_i    (din_b),
    .ren_i     (ren_b),
    .radr_i    (radr_b),
    .data_o    (dout_b),
    .gecerli_o (gecerli_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts the cycles hazir_a stays low, starting from now.
  task automatic wait_ready(output int n, input bit wr, input int poke);
    n = 0;
    while (!hazir_a && n < 1000) begin
      temizle_a = (n == poke);
      if (wr) begin
        wen_a  = 5'h1F;
        wadr_a = 9'd3;
        din_a  = '1;
      end
      n++;
      tick();
    end
    temizle_a = 1'b0;
    wen_a     = '0;
  endtask

  int n;
  int adrs [3] = '{0, 255, 511};

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    temizle_a = 0;
    wen_a     = '0;
    wadr_a    = '0;
    din_a     = '0;
    ren_a     = 0;
    radr_a    = '0;
    temizle_b = 0;
    wen_b     = '0;
    wadr_b    = '0;
    din_b     = '0;
    ren_b     = 0;
    radr_b    = '0;

    repeat (3) tick();
    check("rst_hazir", 64'(hazir_a), 64'd0);
    check("rst_gecerli", 64'(gecerli_a), 64'd0);
    check("rst_data", 64'(dout_a), 64'd0);
    check("rst_hazir_b", 64'(gecerli_b), 64'd0);

    rst = 1'b0;
    wait_ready(n, 1'b0, -1);
    check("clr_len", 64'(n), 64'd512);

    ren_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      radr_a = 9'(adrs[i]);
      tick();
      check("clr_rd", 64'(dout_a), 64'd0);
      check("clr_vld", 64'(gecerli_a), 64'd1);
    end

    ren_a  = 1'b0;
    wen_a  = 5'b11111;
    wadr_a = 9'd7;
    din_a  = 41'h1_AABBCCDDEE;
    tick();
    wen_a = 5'b00101;
    din_a = 41'h0_1122334455;
    tick();
    wen_a  = '0;
    ren_a  = 1'b1;
    radr_a = 9'd7;
    tick();
    check("lanes", 64'(dout_a), 64'h1_AABB33DD55);
    ren_a = 1'b0;
    tick();
    check("hold_vld", 64'(gecerli_a), 64'd0);
    check("hold_data", 64'(dout_a), 64'h1_AABB33DD55);

    wen_a  = 5'b10000;
    wadr_a = 9'd9;
    din_a  = 41'h1_FFFFFFFFFF;
    ren_a  = 1'b1;
    radr_a = 9'd9;
    tick();
    check("fwd", 64'(dout_a), 64'h1_FF00000000);
    check("fwd_vld", 64'(gecerli_a), 64'd1);
    wen_a = '0;
    tick();
    check("fwd_mem", 64'(dout_a), 64'h1_FF00000000);

    wen_b  = 4'hF;
    wadr_b = 3'd5;
    din_b  = 32'hDEADBEEF;
    radr_b = 3'd5;
    #1;
    check("b_rdfirst", 64'(dout_b), 64'd0);
    check("b_vld", 64'(gecerli_b), 64'd1);
    tick();
    check("b_wr", 64'(dout_b), 64'hDEADBEEF);
    wadr_b = 3'd6;
    din_b  = 32'h12345678;
    tick();
    wen_b  = '0;
    radr_b = 3'd6;
    #1;
    check("b_oor6", 64'(dout_b), 64'd0);
    radr_b = 3'd7;
    #1;
    check("b_oor7", 64'(dout_b), 64'd0);
    radr_b = 3'd5;
    #1;
    check("b_keep", 64'(dout_b), 64'hDEADBEEF);

    ren_a = 1'b0;
    repeat (10) tick();
    temizle_a = 1'b1;
    wen_a     = 5'h1F;
    wadr_a    = 9'd7;
    din_a     = '1;
    tick();
    temizle_a = 1'b0;
    wen_a     = '0;
    check("req_hazir", 64'(hazir_a), 64'd0);
    ren_a  = 1'b1;
    radr_a = 9'd9;
    tick();
    check("req_rd", 64'(dout_a), 64'd0);
    check("req_vld", 64'(gecerli_a), 64'd0);
    ren_a = 1'b0;
    wait_ready(n, 1'b1, 50);
    check("req_len", 64'(n + 1), 64'd512);

    ren_a  = 1'b1;
    radr_a = 9'd3;
    tick();
    check("drop3", 64'(dout_a), 64'd0);
    radr_a = 9'd7;
    tick();
    check("clr7", 64'(dout_a), 64'd0);
    radr_a = 9'd9;
    tick();
    check("clr9", 64'(dout_a), 64'd0);
    ren_a = 1'b0;

    temizle_a = 1'b1;
    tick();
    temizle_a = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_data", 64'(dout_a), 64'd0);
    wait_ready(n, 1'b0, -1);
    check("mid_rst_len", 64'(n), 64'd512);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/onbellek_ffram.md
# onbellek_ffram

Parametrised successor to the instruction-cache data RAM: a one-write/one-read flip-flop RAM with per-byte write enables, configurable byte-lane count, extra side bits, depth and read mode. It adds a built-in clear sequencer that zeroes every word after reset or on request, and write-to-read forwarding in registered-read mode. It sits under the instruction and data cache controllers as their data/tag storage.

## Interface
Parameters:
- BYTES_N, 5, number of 8-bit byte lanes.
- EXTRA_BITS, 1, side bits above the top byte lane (valid/flag bits); 0 allowed.
- DEPTH, 512, number of words; ≥2, need not be a power of two.
- REG_READ, 1, 1 = synchronous registered read, 0 = asynchronous combinational read.
- Derived (localparam): DATA_W = 8*BYTES_N + EXTRA_BITS; ADDR_W = $clog2(DEPTH).

Ports:
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- temizle_i  in  1  request a full clear of the RAM.
- hazir_o  out  1  RAM ready; low while clearing.
- wen_i  in  BYTES_N  per-lane write enable; bit k covers data bits [8k+7:8k]; bit BYTES_N-1 also covers the EXTRA_BITS side bits.
- wadr_i  in  ADDR_W  write address.
- data_i  in  DATA_W  write data.
- ren_i  in  1  read enable (used only when REG_READ=1).
- radr_i  in  ADDR_W  read address.
- data_o  out  DATA_W  read data.
- gecerli_o  out  1  data_o valid.

## Operation
- Two-state clear FSM: TEMIZLE, HAZIR. Counter sayac (ADDR_W bits).
- rst_i high: state ← TEMIZLE, sayac ← 0, data_o ← 0, gecerli_o ← 0. hazir_o is 0 in reset and throughout TEMIZLE.
- TEMIZLE: each cycle writes all-zero DATA_W to RAM[sayac], sayac+1. On the cycle sayac = DEPTH-1 is written, next state HAZIR, sayac ← 0.
- HAZIR: temizle_i=1 → next state TEMIZLE, sayac ← 0. Any write issued in that same cycle is still performed and is then cleared.
- temizle_i in TEMIZLE is ignored; the sequence does not restart. rst_i mid-clear restarts at address 0.
- User writes in TEMIZLE are dropped. In HAZIR, lanes with wen_i bit set update RAM[wadr_i]; other lanes hold.
- Addresses ≥ DEPTH (non-power-of-two DEPTH): writes ignored; reads return 0.
- REG_READ=1, HAZIR: ren_i=1 → data_o ← RAM[radr_i], gecerli_o ← 1. ren_i=0 → data_o holds, gecerli_o ← 0.
- Forwarding (REG_READ=1): ren_i, a write and radr_i = wadr_i in the same HAZIR cycle give write-first data. Enabled lanes return data_i; disabled lanes return old RAM content.
- REG_READ=1, TEMIZLE: ren_i accepted; data_o ← 0, gecerli_o ← 0.
- REG_READ=0: data_o = RAM[radr_i] combinationally, read-first; the write is visible after the edge. gecerli_o = hazir_o. ren_i unused. During TEMIZLE, data_o is the current RAM content and is not forced to 0.

## Timing
- Clear latency: with rst_i released before edge 0, words 0..DEPTH-1 are cleared at edges 0..DEPTH-1. hazir_o = 1 after edge DEPTH-1, i.e. DEPTH cycles.
- temizle_i sampled at edge t in HAZIR: hazir_o = 0 after t. hazir_o = 1 again after edge t+DEPTH.
- Registered read latency: 1 cycle (address at edge t, data_o/gecerli_o valid after t). Asynchronous read latency: 0.
- Write latency: 1 edge. Back-to-back writes and reads every cycle, no stalls in HAZIR.
- No output changes except on clk_i edges (REG_READ=1).

## Test plan
- Reset, DEPTH=512: rst_i 1 for 3 cycles then 0 → hazir_o 0 for exactly 512 cycles, then 1. Read of addresses 0, 255, 511 → 0, gecerli_o 1.
- Byte lanes: write 41'h1_AABBCCDDEE to addr 7 with wen_i=5'b11111, then data_i=41'h0_1122334455 with wen_i=5'b00101 → read addr 7 = 41'h1_AABB33DD55.
- Forwarding: addr 9 holds 41'h0_0000000000. Same cycle: write 41'h1_FFFFFFFFFF with wen_i=5'b10000 and read addr 9 → data_o = 41'h1_FF00000000 next cycle.
- Mid-operation clear and reset: temizle_i at cycle 10 after ready → writes during clear dropped, all reads 0 after hazir_o returns. rst_i pulsed at clear cycle 100 → hazir_o stays low for a full 512 cycles after release.
- REG_READ=0, DEPTH=6, BYTES_N=4, EXTRA_BITS=0: write 32'hDEADBEEF to addr 5 → same-cycle data_o shows the old value, next cycle shows 32'hDEADBEEF. Write to addr 6 ignored; read addr 7 → 0.
